// File: rtl/seq_detect_ctrl_if.sv
// Host-side bundle for seq_detect_ctrl: config valid/ready channel, run control, serial stream and status.
// master = host/stimulus side, slave = controller side.
interface seq_detect_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic [CNT_W-1:0] cfg_target;
  logic [CNT_W-1:0] cfg_budget;
  logic             start;
  logic             stop;
  logic             in_valid;
  logic             in;
  logic             out;
  logic [CNT_W-1:0] hit_count;
  logic             busy;
  logic             done;

  modport master (
    output cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_budget,
    output start, stop, in_valid, in,
    input  cfg_ready, out, hit_count, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_pattern, cfg_len, cfg_target, cfg_budget,
    input  start, stop, in_valid, in,
    output cfg_ready, out, hit_count, busy, done
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// Programmable overlapping serial pattern detector with hit/bit limits; cfg_ready low only while running.
// out is same-cycle as the completing bit, or one cycle later when SEQ_DET_REG_OUT_EN is defined.
module seq_detect_ctrl #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 8
) (
  input logic              clk,
  input logic              rst,
  seq_detect_ctrl_if.slave bus
);

  localparam int CW1 = CNT_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] tgt_q, bud_q;
  logic [PAT_W-2:0] shreg_q;
  logic [LEN_W-1:0] fill_q;
  logic [CNT_W-1:0] bits_q, hits_q;

  logic [LEN_W-1:0] len_eff, cfg_len_clamped;
  logic [PAT_W-1:0] window, mask;
  logic             running, cfg_fire, match, hit_lim, bud_lim, finish;
  logic             busy_c, done_c, cfg_ready_c;

  // len_q resets to 0; treat that as length 1 so an unconfigured run still works
  assign len_eff = (len_q == '0) ? LEN_W'(1) : len_q;

  always_comb begin
    cfg_len_clamped = bus.cfg_len;
    if (bus.cfg_len == '0)
      cfg_len_clamped = LEN_W'(1);
    else if (bus.cfg_len > LEN_W'(PAT_W))
      cfg_len_clamped = LEN_W'(PAT_W);
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < PAT_W; i++)
      mask[i] = (i < int'(len_eff));
  end

  assign window   = {shreg_q, bus.in};
  assign running  = (state_q == RUN);
  assign cfg_fire = bus.cfg_valid & cfg_ready_c;

  assign match = running & bus.in_valid
               & (fill_q >= (len_eff - LEN_W'(1)))
               & (((window ^ pat_q) & mask) == '0);

  assign hit_lim = (tgt_q != '0) & (({1'b0, hits_q} + CW1'(match)) >= {1'b0, tgt_q});
  assign bud_lim = (bud_q != '0) & (({1'b0, bits_q} + CW1'(bus.in_valid)) >= {1'b0, bud_q});
  assign finish  = running & (bus.stop | hit_lim | bud_lim);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    busy_c      = 1'b0;
    done_c      = 1'b0;
    cfg_ready_c = 1'b1;
    case (state_q)
      IDLE: begin
        if (bus.start)
          state_d = RUN;
      end
      RUN: begin
        busy_c      = 1'b1;
        cfg_ready_c = 1'b0;
        if (finish)
          state_d = DONE;
      end
      DONE: begin
        done_c = 1'b1;
        if (bus.start)
          state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q   <= '0;
      len_q   <= '0;
      tgt_q   <= '0;
      bud_q   <= '0;
      shreg_q <= '0;
      fill_q  <= '0;
      bits_q  <= '0;
      hits_q  <= '0;
    end else begin
      if (cfg_fire) begin
        pat_q <= bus.cfg_pattern;
        len_q <= cfg_len_clamped;
        tgt_q <= bus.cfg_target;
        bud_q <= bus.cfg_budget;
      end
      if (!running && bus.start) begin
        shreg_q <= '0;
        fill_q  <= '0;
        bits_q  <= '0;
        hits_q  <= '0;
      end else if (running && bus.in_valid) begin
        // history is kept across matches so overlapping occurrences are found
        shreg_q <= window[PAT_W-2:0];
        if (fill_q < len_eff)
          fill_q <= fill_q + LEN_W'(1);
        if (bits_q != '1)
          bits_q <= bits_q + CNT_W'(1);
        if (match && (hits_q != '1))
          hits_q <= hits_q + CNT_W'(1);
      end
    end
  end

`ifdef SEQ_DET_REG_OUT_EN
  logic out_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_q <= 1'b0;
    else
      out_q <= match;
  end

  assign bus.out = out_q;
`else
  assign bus.out = match;
`endif

  assign bus.cfg_ready = cfg_ready_c;
  assign bus.busy      = busy_c;
  assign bus.done      = done_c;
  assign bus.hit_count = hits_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: directed scenarios plus random runs, scored against a queue-based
// model of received bits that recomputes matches and run-end rules directly.
module tb_seq_detect_ctrl;

  localparam int PAT_W = 8;
  localparam int LEN_W = 4;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst;

  initial forever #5 clk = ~clk;

  seq_detect_ctrl_if #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) bus ();

  seq_detect_ctrl #(.PAT_W(PAT_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: run flags, received-bit history and plain integer counters
  bit         m_run, m_done, m_prev;
  bit         m_hist[$];
  logic [7:0] m_pat;
  int         m_len, m_tgt, m_bud, m_hits, m_bits;

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_prev = 0;
    m_hist.delete();
    m_pat = '0; m_len = 1; m_tgt = 0; m_bud = 0; m_hits = 0; m_bits = 0;
  endfunction

  // true when the last m_len bits received (newest = b) spell the pattern
  function automatic bit model_match(input bit b);
    int n = m_hist.size();
    if (n + 1 < m_len) return 0;
    if (b != m_pat[0]) return 0;
    for (int k = 1; k < m_len; k++)
      if (m_hist[n-k] != m_pat[k]) return 0;
    return 1;
  endfunction

  task automatic tick(input string tag);
    bit mt, fin, eo;
    int hl;
    @(negedge clk);
    mt  = m_run && bus.in_valid && model_match(bus.in);
    fin = m_run && (bus.stop ||
                    (m_tgt != 0 && m_hits + int'(mt) >= m_tgt) ||
                    (m_bud != 0 && m_bits + int'(bus.in_valid) >= m_bud));
`ifdef SEQ_DET_REG_OUT_EN
    eo = m_prev;
`else
    eo = mt;
`endif
    check({tag, "_out"},   32'(bus.out),       32'(eo));
    check({tag, "_busy"},  32'(bus.busy),      32'(m_run));
    check({tag, "_done"},  32'(bus.done),      32'(m_done));
    check({tag, "_rdy"},   32'(bus.cfg_ready), 32'(!m_run));
    check({tag, "_hits"},  32'(bus.hit_count), 32'(m_hits));
    @(posedge clk);
    if (bus.cfg_valid && !m_run) begin
      hl = int'(bus.cfg_len);
      m_pat = bus.cfg_pattern;
      m_len = (hl == 0) ? 1 : (hl > PAT_W) ? PAT_W : hl;
      m_tgt = int'(bus.cfg_target);
      m_bud = int'(bus.cfg_budget);
    end
    if (m_run) begin
      if (bus.in_valid) begin
        m_hist.push_back(bus.in);
        if (m_hist.size() > 16) void'(m_hist.pop_front());
        if (m_bits < 255) m_bits++;
      end
      if (mt && m_hits < 255) m_hits++;
      if (fin) begin
        m_run = 0; m_done = 1;
      end
    end else if (bus.start) begin
      m_run = 1; m_done = 0;
      m_hist.delete();
      m_hits = 0; m_bits = 0;
    end
    m_prev = mt;
    #1;
    bus.cfg_valid = 0;
    bus.start     = 0;
    bus.stop      = 0;
  endtask

  task automatic do_reset();
    #2 rst = 1;
    model_reset();
    @(negedge clk);
    check("rst_busy", 32'(bus.busy),      32'd0);
    check("rst_done", 32'(bus.done),      32'd0);
    check("rst_rdy",  32'(bus.cfg_ready), 32'd1);
    check("rst_hits", 32'(bus.hit_count), 32'd0);
    check("rst_out",  32'(bus.out),       32'd0);
    #1 rst = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l,
                          input logic [7:0] t, input logic [7:0] b);
    bus.cfg_valid   = 1;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_target  = t;
    bus.cfg_budget  = b;
    tick("cfg");
  endtask

  task automatic arm();
    bus.start = 1;
    tick("start");
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input string tag);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) begin
      bus.in_valid = 1;
      bus.in       = v[i];
      tick(tag);
    end
    bus.in_valid = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] gap_iv;
    logic [5:0] gap_bit;
    rst = 1;
    bus.cfg_valid = 0; bus.cfg_pattern = '0; bus.cfg_len = '0;
    bus.cfg_target = '0; bus.cfg_budget = '0;
    bus.start = 0; bus.stop = 0; bus.in_valid = 0; bus.in = 0;
    do_reset();

    // 1: overlapping 1011 in 1011011
    load_cfg(8'b1011, 4'd4, 8'd0, 8'd0);
    arm();
    send_bits(32'b1011011, 7, "t1");
    check("t1_hit_count", 32'(bus.hit_count), 32'd2);
    check("t1_busy",      32'(bus.busy),      32'd1);
    bus.stop = 1;
    tick("t1_stop");

    // 2: target of two hits ends the run
    load_cfg(8'b1011, 4'd4, 8'd2, 8'd0);
    arm();
    send_bits(32'b10111011, 8, "t2");
    check("t2_done",      32'(bus.done),      32'd1);
    check("t2_hit_count", 32'(bus.hit_count), 32'd2);

    // 3: bit budget of five
    load_cfg(8'b1011, 4'd4, 8'd0, 8'd5);
    arm();
    send_bits(32'b11111, 5, "t3");
    check("t3_done",      32'(bus.done),      32'd1);
    check("t3_hit_count", 32'(bus.hit_count), 32'd0);

    // 4: len 0 clamps to 1; config offered while running is refused
    load_cfg(8'b1, 4'd0, 8'd0, 8'd0);
    arm();
    send_bits(32'b11, 2, "t4");
    check("t4_hit_count", 32'(bus.hit_count), 32'd2);
    bus.cfg_valid = 1; bus.cfg_pattern = 8'h00; bus.cfg_len = 4'd4;
    bus.in_valid = 1; bus.in = 1;
    tick("t4_cfgrun");
    bus.in_valid = 0;
    check("t4_cfg_kept", 32'(bus.hit_count), 32'd3);
    bus.stop = 1;
    tick("t4_stop");

    // 5: in_valid gaps do not shift the history
    load_cfg(8'b1011, 4'd4, 8'd0, 8'd0);
    arm();
    gap_iv  = 6'b101011;
    gap_bit = 6'b100011;
    for (int i = 5; i >= 0; i--) begin
      bus.in_valid = gap_iv[i];
      bus.in       = gap_iv[i] ? gap_bit[i] : 1'($urandom_range(0, 1));
      tick("t5");
    end
    bus.in_valid = 0;
    check("t5_hit_count", 32'(bus.hit_count), 32'd1);

    // 6: reset mid-run, then a full pattern is needed again
    send_bits(32'b101, 3, "t6a");
    do_reset();
    load_cfg(8'b1011, 4'd4, 8'd0, 8'd0);
    arm();
    send_bits(32'b1, 1, "t6b");
    check("t6_no_early_hit", 32'(bus.hit_count), 32'd0);
    send_bits(32'b011, 3, "t6c");
    check("t6_hit_count", 32'(bus.hit_count), 32'd1);
    bus.stop = 1; bus.start = 1;
    tick("t6_stopstart");
    check("t6_done", 32'(bus.done), 32'd1);
    check("t6_busy", 32'(bus.busy), 32'd0);

    // random runs, with config, start and stop also poked at odd times
    for (int r = 0; r < 25; r++) begin
      load_cfg(8'($urandom),
               ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 4)),
               8'($urandom_range(0, 5)), 8'($urandom_range(0, 30)));
      arm();
      for (int c = 0; c < 40; c++) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in       = 1'($urandom_range(0, 1));
        bus.stop     = ($urandom_range(0, 39) == 0);
        bus.start    = ($urandom_range(0, 19) == 0);
        if ($urandom_range(0, 9) == 0) begin
          bus.cfg_valid   = 1;
          bus.cfg_pattern = 8'($urandom);
          bus.cfg_len     = 4'($urandom_range(0, 15));
          bus.cfg_target  = 8'($urandom_range(0, 5));
          bus.cfg_budget  = 8'($urandom_range(0, 30));
        end
        tick("rnd");
      end
      bus.in_valid = 0;
      bus.stop = 1;
      tick("rnd_stop");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
